rob: RTL and testbench

- In-order reorder buffer that sits directly upstream of the physical register file.
- Rename/dispatch allocates one entry per instruction, recording its destination physical register and the previous mapping of the same architectural register.
- Entries complete out of order by snooping the shared CDB.
- The head entry retires in order, driving the PRF writeback interface (wb_ena, wb_id, wb_val, old_wb) one entry per cycle.

---
 rtl/rob.sv | 131 +++++++++++++
 tb/tb_rob.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rob.sv
`default_nettype none
// ============================================================================
// Module   : rob
// Purpose  : In-order reorder buffer with CDB snooping and PRF retire port.
// Revision : 1.0
// ============================================================================
module rob #(
  parameter int ROB_DEPTH = 8,
  parameter int PREG_W    = 4,
  parameter int DATA_W    = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         alloc_valid,
  input  logic [PREG_W-1:0]            alloc_preg,
  input  logic [PREG_W-1:0]            alloc_old_preg,
  output logic                         alloc_ready,
  output logic [$clog2(ROB_DEPTH)-1:0] alloc_tag,
  input  logic                         cdb_transmit,
  input  logic [PREG_W-1:0]            cdb_id,
  input  logic [DATA_W-1:0]            cdb_val,
  input  logic                         flush,
  output logic                         wb_ena,
  output logic [PREG_W-1:0]            wb_id,
  output logic [DATA_W-1:0]            wb_val,
  output logic [PREG_W-1:0]            old_wb,
  output logic [$clog2(ROB_DEPTH):0]   count,
  output logic                         empty,
  output logic                         full
);

  localparam int c_IDX_W = $clog2(ROB_DEPTH);
  localparam int c_PTR_W = c_IDX_W + 1;
  localparam logic [c_PTR_W-1:0] c_DEPTH = c_PTR_W'(ROB_DEPTH);

  logic [c_PTR_W-1:0]   r_head;
  logic [c_PTR_W-1:0]   r_tail;
  logic [ROB_DEPTH-1:0] r_valid;
  logic [ROB_DEPTH-1:0] r_done;
  logic [PREG_W-1:0]    r_preg [ROB_DEPTH];
  logic [PREG_W-1:0]    r_old  [ROB_DEPTH];
  logic [DATA_W-1:0]    r_val  [ROB_DEPTH];

  logic [c_PTR_W-1:0]   w_count;
  logic [c_IDX_W-1:0]   w_head_idx;
  logic [c_IDX_W-1:0]   w_tail_idx;
  logic                 w_full;
  logic                 w_alloc;
  logic                 w_retire;
  logic [ROB_DEPTH-1:0] w_cap;

  // The wrap bit makes tail - head range over 0..ROB_DEPTH without ambiguity.
  assign w_count     = r_tail - r_head;
  assign w_full      = (w_count == c_DEPTH);
  assign w_head_idx  = r_head[c_IDX_W-1:0];
  assign w_tail_idx  = r_tail[c_IDX_W-1:0];
  assign w_alloc     = alloc_valid && !w_full && !flush;
  assign w_retire    = r_valid[w_head_idx] && r_done[w_head_idx] && !flush;

  assign count       = w_count;
  assign full        = w_full;
  assign empty       = (w_count == '0);
  assign alloc_ready = !w_full;
  assign alloc_tag   = w_tail_idx;

  generate
    for (genvar i = 0; i < ROB_DEPTH; i++) begin : g_entry
      assign w_cap[i] = cdb_transmit && !flush && r_valid[i] && !r_done[i] &&
                        (r_preg[i] == cdb_id);

      // Payload needs no reset: valid/done gate every use of it.
      always_ff @(posedge clk) begin
        if (w_alloc && (w_tail_idx == c_IDX_W'(i))) begin
          r_preg[i] <= alloc_preg;
          r_old[i]  <= alloc_old_preg;
          r_val[i]  <= '0;
        end else if (w_cap[i]) begin
          r_val[i]  <= cdb_val;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_valid <= '0;
      r_done  <= '0;
      wb_ena  <= 1'b0;
      wb_id   <= '0;
      wb_val  <= '0;
      old_wb  <= '0;
    end else if (flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_valid <= '0;
      r_done  <= '0;
      wb_ena  <= 1'b0;
      wb_id   <= '0;
      wb_val  <= '0;
      old_wb  <= '0;
    end else begin
      for (int i = 0; i < ROB_DEPTH; i++) begin
        if (w_cap[i]) r_done[i] <= 1'b1;
      end
      if (w_retire) begin
        wb_ena              <= 1'b1;
        wb_id               <= r_preg[w_head_idx];
        wb_val              <= r_val[w_head_idx];
        old_wb              <= r_old[w_head_idx];
        r_valid[w_head_idx] <= 1'b0;
        r_done[w_head_idx]  <= 1'b0;
        r_head              <= r_head + 1'b1;
      end else begin
        wb_ena <= 1'b0;
        wb_id  <= '0;
        wb_val <= '0;
        old_wb <= '0;
      end
      // Allocation is applied last so a same-edge CDB match cannot mark it done.
      if (w_alloc) begin
        r_valid[w_tail_idx] <= 1'b1;
        r_done[w_tail_idx]  <= 1'b0;
        r_tail              <= r_tail + 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rob.sv
`default_nettype none
// ============================================================================
// Module   : tb_rob
// Purpose  : Directed and randomized checks of rob against a queue model.
// Revision : 1.0
// ============================================================================
module tb_rob;

  localparam int DEPTH = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       alloc_valid = 1'b0;
  logic [3:0] alloc_preg = '0;
  logic [3:0] alloc_old_preg = '0;
  logic       alloc_ready;
  logic [2:0] alloc_tag;
  logic       cdb_transmit = 1'b0;
  logic [3:0] cdb_id = '0;
  logic [7:0] cdb_val = '0;
  logic       flush = 1'b0;
  logic       wb_ena;
  logic [3:0] wb_id;
  logic [7:0] wb_val;
  logic [3:0] old_wb;
  logic [3:0] count;
  logic       empty;
  logic       full;

  rob #(.ROB_DEPTH(DEPTH), .PREG_W(4), .DATA_W(8)) dut (
    .clk(clk), .rst(rst),
    .alloc_valid(alloc_valid), .alloc_preg(alloc_preg),
    .alloc_old_preg(alloc_old_preg), .alloc_ready(alloc_ready),
    .alloc_tag(alloc_tag),
    .cdb_transmit(cdb_transmit), .cdb_id(cdb_id), .cdb_val(cdb_val),
    .flush(flush),
    .wb_ena(wb_ena), .wb_id(wb_id), .wb_val(wb_val), .old_wb(old_wb),
    .count(count), .empty(empty), .full(full)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] preg;
    logic [3:0] old;
    logic [7:0] val;
    bit         done;
  } ent_t;

  ent_t       q[$];
  int         tail_ptr;
  bit         e_wb_ena;
  logic [3:0] e_wb_id;
  logic [7:0] e_wb_val;
  logic [3:0] e_old_wb;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    tail_ptr = 0;
    e_wb_ena = 0; e_wb_id = '0; e_wb_val = '0; e_old_wb = '0;
  endtask

  // Expected next state from the current inputs and the pre-edge model.
  task automatic model_step();
    bit   ret;
    int   pre;
    ent_t r;
    if (flush) begin
      model_reset();
      return;
    end
    pre = q.size();
    ret = (pre > 0) && q[0].done;
    if (cdb_transmit) begin
      foreach (q[i]) begin
        if (!q[i].done && q[i].preg == cdb_id) begin
          q[i].done = 1;
          q[i].val  = cdb_val;
        end
      end
    end
    if (ret) begin
      r = q.pop_front();
      e_wb_ena = 1; e_wb_id = r.preg; e_wb_val = r.val; e_old_wb = r.old;
    end else begin
      e_wb_ena = 0; e_wb_id = '0; e_wb_val = '0; e_old_wb = '0;
    end
    if (alloc_valid && pre < DEPTH) begin
      q.push_back('{preg: alloc_preg, old: alloc_old_preg, val: 8'h00, done: 0});
      tail_ptr = (tail_ptr + 1) % DEPTH;
    end
  endtask

  task automatic compare_all();
    chk("count",       32'(count),       32'(q.size()));
    chk("empty",       32'(empty),       32'(q.size() == 0));
    chk("full",        32'(full),        32'(q.size() == DEPTH));
    chk("alloc_ready", 32'(alloc_ready), 32'(q.size() < DEPTH));
    chk("alloc_tag",   32'(alloc_tag),   32'(tail_ptr));
    chk("wb_ena",      32'(wb_ena),      32'(e_wb_ena));
    chk("wb_id",       32'(wb_id),       32'(e_wb_id));
    chk("wb_val",      32'(wb_val),      32'(e_wb_val));
    chk("old_wb",      32'(old_wb),      32'(e_old_wb));
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic drive(input bit av, input logic [3:0] ap, input logic [3:0] ao,
                       input bit ct, input logic [3:0] ci, input logic [7:0] cv,
                       input bit fl);
    alloc_valid = av; alloc_preg = ap; alloc_old_preg = ao;
    cdb_transmit = ct; cdb_id = ci; cdb_val = cv; flush = fl;
  endtask

  task automatic idle();
    drive(0, 4'h0, 4'h0, 0, 4'h0, 8'h00, 0);
  endtask

  initial begin
    int k;
    model_reset();
    #12;
    chk("reset_count", 32'(count), 32'd0);
    chk("reset_empty", 32'(empty), 32'd1);
    chk("reset_ready", 32'(alloc_ready), 32'd1);
    chk("reset_wb_ena", 32'(wb_ena), 32'd0);
    rst = 1'b0;

    // Out-of-order completion, in-order retire
    drive(1, 4'd5, 4'd1, 0, 0, 0, 0); tick();
    drive(1, 4'd6, 4'd2, 0, 0, 0, 0); tick();
    drive(1, 4'd7, 4'd3, 0, 0, 0, 0); tick();
    chk("t1_count3", 32'(count), 32'd3);
    drive(0, 0, 0, 1, 4'd7, 8'h33, 0); tick();
    chk("t1_no_wb_a", 32'(wb_ena), 32'd0);
    drive(0, 0, 0, 1, 4'd5, 8'h11, 0); tick();
    chk("t1_no_wb_b", 32'(wb_ena), 32'd0);
    drive(0, 0, 0, 1, 4'd6, 8'h22, 0); tick();
    chk("t1_r1_ena", 32'(wb_ena), 32'd1);
    chk("t1_r1_id",  32'(wb_id),  32'd5);
    chk("t1_r1_val", 32'(wb_val), 32'h11);
    chk("t1_r1_old", 32'(old_wb), 32'd1);
    idle(); tick();
    chk("t1_r2_id",  32'(wb_id),  32'd6);
    chk("t1_r2_val", 32'(wb_val), 32'h22);
    chk("t1_r2_old", 32'(old_wb), 32'd2);
    tick();
    chk("t1_r3_id",  32'(wb_id),  32'd7);
    chk("t1_r3_val", 32'(wb_val), 32'h33);
    tick();
    chk("t1_end_ena",   32'(wb_ena), 32'd0);
    chk("t1_end_empty", 32'(empty),  32'd1);

    // Fill to capacity, then an ignored ninth request
    for (int i = 0; i < DEPTH; i++) begin
      drive(1, 4'(i), 4'(i + 8), 0, 0, 0, 0); tick();
    end
    chk("t2_full",  32'(full),        32'd1);
    chk("t2_ready", 32'(alloc_ready), 32'd0);
    chk("t2_count", 32'(count),       32'd8);
    drive(1, 4'hF, 4'hF, 0, 0, 0, 0); tick();
    chk("t2_count_hold", 32'(count), 32'd8);
    drive(0, 0, 0, 0, 0, 0, 1); tick();
    chk("t2_flush_tag", 32'(alloc_tag), 32'd0);

    // Same-edge allocate and CDB match: the new entry must stay pending
    drive(1, 4'd9, 4'd0, 1, 4'd9, 8'h77, 0); tick();
    idle();
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t4_no_wb", 32'(wb_ena), 32'd0);
    end
    drive(0, 0, 0, 1, 4'd9, 8'h5A, 0); tick();
    idle(); tick();
    chk("t4_ena", 32'(wb_ena), 32'd1);
    chk("t4_val", 32'(wb_val), 32'h5A);
    tick();

    // Flush with completed entries outstanding
    for (int i = 1; i <= 4; i++) begin
      drive(1, 4'(i), 4'(i), 0, 0, 0, 0); tick();
    end
    drive(0, 0, 0, 1, 4'd3, 8'hC3, 0); tick();
    drive(0, 0, 0, 1, 4'd4, 8'hC4, 0); tick();
    drive(0, 0, 0, 0, 0, 0, 1); tick();
    chk("t5_count", 32'(count), 32'd0);
    chk("t5_empty", 32'(empty), 32'd1);
    idle(); tick();
    chk("t5_no_wb", 32'(wb_ena), 32'd0);
    drive(0, 0, 0, 1, 4'd1, 8'hA1, 0); tick();
    drive(0, 0, 0, 1, 4'd2, 8'hA2, 0); tick();
    idle(); tick();
    chk("t5_no_wb_late", 32'(wb_ena), 32'd0);

    // Asynchronous reset between edges
    for (int i = 0; i < 6; i++) begin
      drive(1, 4'(10 + i), 4'(i), 0, 0, 0, 0); tick();
    end
    drive(0, 0, 0, 1, 4'd10, 8'hEE, 0); tick();
    idle(); tick();
    chk("t6_pre_ena",   32'(wb_ena), 32'd1);
    chk("t6_pre_count", 32'(count),  32'd5);
    #2 rst = 1'b1;
    #1;
    chk("t6_rst_ena",   32'(wb_ena),    32'd0);
    chk("t6_rst_count", 32'(count),     32'd0);
    chk("t6_rst_empty", 32'(empty),     32'd1);
    chk("t6_rst_tag",   32'(alloc_tag), 32'd0);
    chk("t6_rst_ready", 32'(alloc_ready), 32'd1);
    model_reset();
    rst = 1'b0;
    drive(1, 4'd2, 4'd3, 0, 0, 0, 0); tick();
    chk("t6_tag_after", 32'(alloc_tag), 32'd1);

    // Randomized traffic against the queue model
    for (int n = 0; n < 3000; n++) begin
      alloc_valid    = ($urandom_range(0, 99) < 60);
      alloc_preg     = 4'($urandom);
      alloc_old_preg = 4'($urandom);
      cdb_transmit   = ($urandom_range(0, 99) < 55);
      cdb_val        = 8'($urandom);
      cdb_id         = 4'($urandom);
      if (q.size() > 0 && $urandom_range(0, 3) != 0) begin
        k = $urandom_range(0, q.size() - 1);
        cdb_id = q[k].preg;
      end
      flush = ($urandom_range(0, 199) == 0);
      tick();
    end

    idle(); tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
